shift_register: RTL and testbench
=================================

SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the register length in bits; legal range is 2 or more.
REQ-002 The module SHALL have parameter RESET_VALUE, default all-zeros (WIDTH bits), giving the value q takes during reset.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit, a synchronous active-low reset.
REQ-005 The module SHALL have port data, input, 1 bit, the serial bit shifted in.
REQ-006 The module SHALL have port shift_enable, input, 1 bit; when high, a shift occurs at the next rising clk edge.
REQ-007 The module SHALL have port q, output, WIDTH bits (8 by default), the parallel register contents, driven directly from flops.

Function
REQ-008 On a rising clk edge with reset_n=1 and shift_enable=1, the module SHALL load q <= {q[WIDTH-2:0], data}, so data enters at the LSB, every other bit moves one place toward the MSB, and the old MSB is discarded.
REQ-009 On a rising clk edge with reset_n=1 and shift_enable=0, q SHALL hold its value.
REQ-010 Latency: data sampled at edge N SHALL appear on q[0] after edge N, and on q[k] after edge N+k if shift_enable stays high.
REQ-011 The module SHALL have no handshake; every enabled edge performs exactly one shift, with no full or empty condition.
REQ-012 q SHALL change only on rising clk edges; there SHALL be no combinational path from data or shift_enable to q.
REQ-013 An X on data during an enabled shift SHALL propagate as-is; no masking is required.

Reset
REQ-014 On a rising clk edge with reset_n=0, q SHALL become RESET_VALUE (00000000 by default).
REQ-015 Reset SHALL take priority over shift_enable; asserting reset mid-sequence discards all shifted data at that edge.
REQ-016 Reset SHALL be synchronous only; asserting reset_n between edges SHALL NOT change q until the next rising edge.
REQ-017 After reset_n deasserts, the first enabled edge SHALL shift normally, with no dead cycle.

Structure
REQ-018 The design SHALL be a single flat module with one WIDTH-bit register and no sub-modules.
REQ-019 No shared package is required; WIDTH and RESET_VALUE SHALL be module parameters only.

Verification
(Clock period 10, stimulus changes away from rising edges, default parameters.)
REQ-020 Bench SHALL verify reset: reset_n=0 for at least 1 edge, then 1 with shift_enable=0 -> q=00000000 and q holds over idle edges.
REQ-021 Bench SHALL verify a single shift: data=1, shift_enable=1 for one edge, then 0 -> q=00000001; shifting data=0 for one more edge -> q=00000010.
REQ-022 Bench SHALL verify a continuous run from q=00000010: shift 1, then six 0s, then 1 on consecutive edges, then shift_enable=0 -> q=10000001, showing MSB overflow is discarded.
REQ-023 Bench SHALL verify hold: shift_enable=0 with data toggling for 5 edges -> q unchanged.
REQ-024 Bench SHALL verify reset mid-operation: from q=10000001, reset_n=0 with shift_enable=1 and data=1 -> q=00000000 after that edge; after reset_n=1, the next enabled shift of 1 -> q=00000001.
REQ-025 Bench SHALL verify synchronous reset: pulse reset_n low between edges, returning high before the next edge -> q unchanged.

Source files
------------

// File: rtl/shift_register.sv
// Serial-in, parallel-out shift register.
// Data enters at the LSB, and every stored bit moves one place toward the MSB.
// The old MSB is dropped on each enabled edge.
// Reset is synchronous and active-low, and it wins over shift_enable.
module shift_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             data,
    input  logic             shift_enable,
    output logic [WIDTH-1:0] q
);

    // A one-bit register has no q[WIDTH-2:0] slice to shift, so reject it at elaboration.
    generate
        if (WIDTH < 2) begin : g_width_check
            $error("shift_register: WIDTH must be 2 or more");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;

    // Register update: reset first, then shift when enabled, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q <= RESET_VALUE;
        end else if (shift_enable) begin
            r_q <= {r_q[WIDTH-2:0], data};
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register with the default parameters.
// A vector table covers the directed sequences.
// Hand-written steps cover the between-edge reset pulse and the absence of a combinational path.
// A model-driven random run finishes the test.
module tb_shift_register;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             data;
    logic             shift_enable;
    logic [WIDTH-1:0] q;

    int checks;
    int errors;

    typedef struct {
        logic             rn;
        logic             se;
        logic             d;
        logic [WIDTH-1:0] exp;
        string            name;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] exp;
        string            name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    shift_register #(
        .WIDTH      (WIDTH),
        .RESET_VALUE('0)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data        (data),
        .shift_enable(shift_enable),
        .q           (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rn, input logic se, input logic d,
                           input logic [WIDTH-1:0] exp, input string name);
        vec_t v;
        v.rn = rn; v.se = se; v.d = d; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one cycle on the falling edge, queue its expectation, and compare just after the rising edge.
    task automatic step(input logic rn, input logic se, input logic d,
                        input logic [WIDTH-1:0] exp, input string name);
        sb_t e;
        @(negedge clk);
        reset_n      = rn;
        shift_enable = se;
        data         = d;
        e.exp = exp; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: actual=empty scoreboard required=entry", name);
        end else begin
            e = sb.pop_front();
            check(e.name, q, e.exp);
        end
    endtask

    logic [WIDTH-1:0] model_q;

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        shift_enable = 1'b0;
        data         = 1'b0;

        // reset and idle
        add_vec(0, 0, 0, 8'h00, "reset_edge");
        add_vec(0, 1, 1, 8'h00, "reset_over_shift");
        add_vec(1, 0, 0, 8'h00, "idle_0");
        add_vec(1, 0, 1, 8'h00, "idle_1");
        // single shift
        add_vec(1, 1, 1, 8'h01, "shift_one");
        add_vec(1, 0, 0, 8'h01, "hold_after_one");
        add_vec(1, 1, 0, 8'h02, "shift_zero");
        // continuous run with MSB overflow
        add_vec(1, 1, 1, 8'h05, "run_1");
        add_vec(1, 1, 0, 8'h0A, "run_0a");
        add_vec(1, 1, 0, 8'h14, "run_0b");
        add_vec(1, 1, 0, 8'h28, "run_0c");
        add_vec(1, 1, 0, 8'h50, "run_0d");
        add_vec(1, 1, 0, 8'hA0, "run_0e");
        add_vec(1, 1, 0, 8'h40, "run_0f_msb_drop");
        add_vec(1, 1, 1, 8'h81, "run_last_1");
        add_vec(1, 0, 0, 8'h81, "run_stop");
        // hold with data toggling
        for (int i = 0; i < 5; i++)
            add_vec(1, 0, logic'(i[0] == 1'b0), 8'h81, $sformatf("hold_%0d", i));
        // reset mid-operation, then no dead cycle after release
        add_vec(0, 1, 1, 8'h00, "reset_mid");
        add_vec(1, 1, 1, 8'h01, "first_after_reset");

        foreach (vecs[i])
            step(vecs[i].rn, vecs[i].se, vecs[i].d, vecs[i].exp, vecs[i].name);

        // A reset pulse that ends before the next edge must leave q untouched.
        @(negedge clk);
        shift_enable = 1'b0;
        #1 reset_n = 1'b0;
        #2 check("sync_reset_during_pulse", q, 8'h01);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check("sync_reset_after_edge", q, 8'h01);

        // Enable and data moving between edges must not reach q before the edge.
        @(negedge clk);
        shift_enable = 1'b1;
        data         = 1'b1;
        #2 check("no_comb_path", q, 8'h01);
        @(posedge clk);
        #1 check("shift_after_comb_check", q, 8'h03);

        // Random run checked against an independent reference model.
        model_q = 8'h03;
        for (int i = 0; i < 40; i++) begin
            logic rn, se, d;
            rn = ($urandom_range(0, 9) != 0);
            se = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            if (!rn)
                model_q = '0;
            else if (se)
                model_q = (model_q << 1) | {{(WIDTH-1){1'b0}}, d};
            step(rn, se, d, model_q, $sformatf("random_%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
